regfile_write_arbiter: RTL and testbench

//  Upstream write-port controller for the 32x64-bit register file built from 64-bit enable registers.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/rf_addr_decoder.sv | 16 +
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing, write-request type and arbitration source encoding for the
// register-file write-port controller.
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_HOLD,
    SRC_LOAD,
    SRC_ALU
  } rf_src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request, write-port and forwarding signals between the writeback sources,
// the register file and the read ports.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_addr;
  logic [DATA_W-1:0]   alu_data;
  logic                ld_valid;
  logic                ld_ready;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic                fwd_hit_a;
  logic                fwd_hit_b;
  logic [DATA_W-1:0]   fwd_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    output rd_addr_a, rd_addr_b,
    input  alu_ready, ld_ready, wr_en, wr_data,
    input  fwd_hit_a, fwd_hit_b, fwd_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    input  rd_addr_a, rd_addr_b,
    output alu_ready, ld_ready, wr_en, wr_data,
    output fwd_hit_a, fwd_hit_b, fwd_data
  );

endinterface

// File: rtl/rf_addr_decoder.sv
// Register address to one-hot write enable; the hardwired-zero register never
// receives an enable.
module rf_addr_decoder
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (addr != ZERO_REG)) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load writebacks onto the single register-file write port,
// with a one-entry holding slot for displaced ALU results and read forwarding.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

  logic                h_valid;
  rf_wr_req_t          h_req;
  logic [3:0]          age;
  logic [NUM_REGS-1:0] wr_en_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [ADDR_W-1:0]   o_addr;

  logic                starved;
  logic                capture;
  rf_src_e             src;
  rf_wr_req_t          win_req;
  logic [NUM_REGS-1:0] dec_en;
  logic [NUM_REGS-1:0] wr_en_gated;

  always_comb begin
    starved       = h_valid && (age == AGE_MAX);
    bus.alu_ready = !rst && !h_valid;
    bus.ld_ready  = !rst && !starved;

    src = SRC_NONE;
    if (!rst) begin
      if (starved)            src = SRC_HOLD;
      else if (bus.ld_valid)  src = SRC_LOAD;
      else if (h_valid)       src = SRC_HOLD;
      else if (bus.alu_valid) src = SRC_ALU;
    end

    // An ALU request is only accepted with H empty, so losing means a load won.
    capture = !rst && bus.alu_valid && !h_valid && (src == SRC_LOAD);

    win_req = '0;
    case (src)
      SRC_HOLD: win_req = h_req;
      SRC_LOAD: win_req = '{addr: bus.ld_addr, data: bus.ld_data};
      SRC_ALU:  win_req = '{addr: bus.alu_addr, data: bus.alu_data};
      default:  win_req = '0;
    endcase
  end

  rf_addr_decoder u_dec (
    .addr   (win_req.addr),
    .en     (src != SRC_NONE),
    .onehot (dec_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid   <= 1'b0;
      h_req     <= '0;
      age       <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      o_addr    <= '0;
    end else begin
      wr_en_q   <= dec_en;
      wr_data_q <= win_req.data;
      o_addr    <= win_req.addr;

      if (src == SRC_HOLD) begin
        h_valid <= 1'b0;
      end else if (capture) begin
        h_valid <= 1'b1;
        h_req   <= '{addr: bus.alu_addr, data: bus.alu_data};
      end

      if (h_valid && (src != SRC_HOLD))
        age <= (age == AGE_MAX) ? age : age + 4'd1;
      else
        age <= '0;
    end
  end

  // A write pending when reset arrives is suppressed immediately, not one edge later.
  assign wr_en_gated   = rst ? '0 : wr_en_q;
  assign bus.wr_en     = wr_en_gated;
  assign bus.wr_data   = wr_data_q;
  assign bus.fwd_data  = wr_data_q;
  assign bus.fwd_hit_a = (|wr_en_gated) && (o_addr == bus.rd_addr_a);
  assign bus.fwd_hit_b = (|wr_en_gated) && (o_addr == bus.rd_addr_b);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table plus hand-written starvation and reset sequences for
// the register-file write arbiter.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [63:0] ld;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        e_ar;
    logic        e_lr;
    logic [31:0] e_wen;
    logic        chk_d;
    logic [63:0] e_wd;
    logic        e_fa;
    logic        e_fb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic lv, input logic [4:0] la, input logic [63:0] ld,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ld;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
  endtask

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [63:0] ad,
                              logic lv, logic [4:0] la, logic [63:0] ld,
                              logic [4:0] ra, logic [4:0] rb,
                              logic e_ar, logic e_lr, logic [31:0] e_wen,
                              logic chk_d, logic [63:0] e_wd, logic e_fa, logic e_fb);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.lv = lv; v.la = la; v.ld = ld;
    v.ra = ra; v.rb = rb;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_wen = e_wen;
    v.chk_d = chk_d; v.e_wd = e_wd; v.e_fa = e_fa; v.e_fb = e_fb;
    return v;
  endfunction

  initial begin
    int ld_low;
    tests = 0;
    fails = 0;

    //           av aa     ad        lv la     ld      ra     rb     ar lr wen           cd wd        fa fb
    vecs[0]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd0,  5'd0,  1, 1, 32'h0,        1, 64'h0,    0, 0);
    vecs[1]  = mk(1, 5'd3,  64'hAAAA, 0, 5'd0, 64'h0,  5'd0,  5'd0,  1, 1, 32'h0,        0, 64'h0,    0, 0);
    vecs[2]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd3,  5'd0,  1, 1, 32'h8,        1, 64'hAAAA, 1, 0);
    vecs[3]  = mk(1, 5'd6,  64'h22,   1, 5'd5, 64'h11, 5'd0,  5'd0,  1, 1, 32'h0,        0, 64'h0,    0, 0);
    vecs[4]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd5,  5'd6,  0, 1, 32'h20,       1, 64'h11,   1, 0);
    vecs[5]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd5,  5'd6,  1, 1, 32'h40,       1, 64'h22,   0, 1);
    vecs[6]  = mk(1, 5'd31, 64'hDEAD, 0, 5'd0, 64'h0,  5'd31, 5'd0,  1, 1, 32'h0,        0, 64'h0,    0, 0);
    vecs[7]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd31, 5'd31, 1, 1, 32'h0,        0, 64'h0,    0, 0);
    vecs[8]  = mk(1, 5'd7,  64'h1234, 0, 5'd0, 64'h0,  5'd0,  5'd0,  1, 1, 32'h0,        0, 64'h0,    0, 0);
    vecs[9]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd7,  5'd8,  1, 1, 32'h80,       1, 64'h1234, 1, 0);
    vecs[10] = mk(0, 5'd0,  64'h0,    1, 5'd9, 64'h99, 5'd9,  5'd0,  1, 1, 32'h0,        0, 64'h0,    0, 0);
    vecs[11] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  5'd9,  5'd9,  1, 1, 32'h200,      1, 64'h99,   1, 1);

    rst = 1'b1;
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd0, 5'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'h0);
    chk("rst_ld_ready",  64'(bus.ld_ready),  64'h0);
    chk("rst_wr_en",     64'(bus.wr_en),     64'h0);
    chk("rst_fwd_hit_a", 64'(bus.fwd_hit_a), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld,
            vecs[i].ra, vecs[i].rb);
      @(negedge clk);
      chk($sformatf("v%0d_alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].e_ar));
      chk($sformatf("v%0d_ld_ready", i),  64'(bus.ld_ready),  64'(vecs[i].e_lr));
      chk($sformatf("v%0d_wr_en", i),     64'(bus.wr_en),     64'(vecs[i].e_wen));
      chk($sformatf("v%0d_fwd_hit_a", i), 64'(bus.fwd_hit_a), 64'(vecs[i].e_fa));
      chk($sformatf("v%0d_fwd_hit_b", i), 64'(bus.fwd_hit_b), 64'(vecs[i].e_fb));
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d_wr_data", i),  bus.wr_data,  vecs[i].e_wd);
        chk($sformatf("v%0d_fwd_data", i), bus.fwd_data, vecs[i].e_wd);
      end
      @(posedge clk); #1;
    end

    // Starvation: ALU to r12 displaced by a load, then loads every cycle.
    ld_low = 0;
    for (int i = 0; i <= 6; i++) begin
      logic [4:0]  la;
      logic [63:0] ldd;
      logic [31:0] exp_wen;
      logic [63:0] exp_wd;
      la  = (i <= 5) ? 5'(16 + i) : 5'd21;
      ldd = (i <= 5) ? 64'(32'h100 + i) : 64'h105;
      drive(i == 0, 5'd12, 64'hA5A5, 1'b1, la, ldd, 5'd0, 5'd0);
      @(negedge clk);
      if (!bus.ld_ready) ld_low++;
      chk($sformatf("st%0d_alu_ready", i), 64'(bus.alu_ready), 64'((i == 0) || (i == 6)));
      chk($sformatf("st%0d_ld_ready", i),  64'(bus.ld_ready),  64'(i != 5));
      if (i == 0) begin
        exp_wen = 32'h0;
        exp_wd  = 64'h0;
      end else if (i <= 5) begin
        exp_wen = 32'h1 << (15 + i);
        exp_wd  = 64'(32'h100 + i - 1);
      end else begin
        exp_wen = 32'h1 << 12;
        exp_wd  = 64'hA5A5;
      end
      chk($sformatf("st%0d_wr_en", i), 64'(bus.wr_en), 64'(exp_wen));
      if (i != 0) chk($sformatf("st%0d_wr_data", i), bus.wr_data, exp_wd);
      @(posedge clk); #1;
    end
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd21, 5'd0);
    @(negedge clk);
    chk("st7_wr_en",     64'(bus.wr_en),     64'(32'h1 << 21));
    chk("st7_wr_data",   bus.wr_data,        64'h105);
    chk("st7_fwd_hit_a", 64'(bus.fwd_hit_a), 64'h1);
    chk("st_ld_ready_low_cycles", 64'(ld_low), 64'h1);
    @(posedge clk); #1;

    // Reset with H full and a load write pending at the output.
    drive(1, 5'd2, 64'h2, 1, 5'd1, 64'h1, 5'd1, 5'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd1, 5'd2);
    @(negedge clk);
    chk("mr_wr_en_during",  64'(bus.wr_en),     64'h0);
    chk("mr_fwd_hit_a",     64'(bus.fwd_hit_a), 64'h0);
    chk("mr_alu_ready",     64'(bus.alu_ready), 64'h0);
    chk("mr_ld_ready",      64'(bus.ld_ready),  64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_wr_en_after",   64'(bus.wr_en),     64'h0);
    chk("mr_alu_ready_after", 64'(bus.alu_ready), 64'h1);
    chk("mr_ld_ready_after",  64'(bus.ld_ready),  64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_wr_en_h_dropped", 64'(bus.wr_en),   64'h0);
    chk("mr_fwd_hit_b",     64'(bus.fwd_hit_b), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
